shift_arbiter: RTL and testbench

Shares the single 16-bit combinational barrel shifter (SLL/SRA/ROR, 4-bit amount) between two requesters, the execute stage (port 0) and the multi-cycle/auxiliary unit (port 1). Round-robin arbitration, valid/ready handshake on both request and response sides, operands and result registered. It sits between the requesters and the shifter instance it owns internally.

---
 rtl/shift_arbiter.sv | 138 +++++++++++++
 tb/tb_shift_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one 16-bit barrel shifter
// (SLL / SRA / ROR, 4-bit amount) between two requesters. Operands are latched
// on grant, shifted in EXEC, and the result is held in RESP until consumed.
module shift_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_rs,
   input  logic [3:0]  req0_amt,
   input  logic [1:0]  req0_mode,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_rs,
   input  logic [3:0]  req1_amt,
   input  logic [1:0]  req1_mode,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_prio;
   logic [15:0] r_rs;
   logic [3:0]  r_amt;
   logic [1:0]  r_mode;
   logic        r_id;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [15:0] r_rsp_data;
   logic        r_busy;

   logic        w_accept_en;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_any_grant;
   logic [15:0] w_shift_res;

   // Barrel shifter. Mode 11 behaves as SRA; ROR uses a doubled operand so
   // that amount 0 naturally returns the operand unchanged.
   function automatic logic [15:0] f_shift(input logic [15:0] rs,
                                           input logic [3:0]  amt,
                                           input logic [1:0]  mode);
      logic [31:0]        dbl;
      logic signed [15:0] srs;
      logic [15:0]        res;
      dbl = {rs, rs} >> amt;
      srs = rs;
      case (mode)
         2'b00:   res = rs << amt;
         2'b10:   res = dbl[15:0];
         default: res = srs >>> amt;
      endcase
      return res;
   endfunction

   // Requests may only be accepted in IDLE or while the held result is being
   // consumed; readys are forced low while reset is asserted.
   assign w_accept_en = !rst && ((r_state == S_IDLE) ||
                                 ((r_state == S_RESP) && rsp_ready));

   // Round robin: a lone requester always wins, a tie goes to port r_prio.
   assign w_grant0    = w_accept_en && req0_valid && (!req1_valid || !r_prio);
   assign w_grant1    = w_accept_en && req1_valid && (!req0_valid ||  r_prio);
   assign w_any_grant = w_grant0 || w_grant1;

   assign w_shift_res = f_shift(r_rs, r_amt, r_mode);

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign busy       = r_busy;

   // Control FSM with registered outputs; a grant latches the winner's operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_prio      <= 1'b0;
         r_rs        <= 16'h0000;
         r_amt       <= 4'h0;
         r_mode      <= 2'b00;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= 16'h0000;
         r_busy      <= 1'b0;
      end else begin
         if (w_any_grant) begin
            r_rs   <= w_grant1 ? req1_rs   : req0_rs;
            r_amt  <= w_grant1 ? req1_amt  : req0_amt;
            r_mode <= w_grant1 ? req1_mode : req0_mode;
            r_id   <= w_grant1;
            r_prio <= w_grant0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_any_grant) begin
                  r_state <= S_EXEC;
                  r_busy  <= 1'b1;
               end
            end
            S_EXEC: begin
               r_rsp_data  <= w_shift_res;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_any_grant) begin
                     r_state <= S_EXEC;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vector table, round-robin, backpressure
// and mid-operation reset sequences, with a scoreboard on the response port.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [15:0] req0_rs;
   logic [3:0]  req0_amt;
   logic [1:0]  req0_mode;
   logic        req1_valid, req1_ready;
   logic [15:0] req1_rs;
   logic [3:0]  req1_amt;
   logic [1:0]  req1_mode;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   shift_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs(req0_rs),
      .req0_amt(req0_amt), .req0_mode(req0_mode),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs(req1_rs),
      .req1_amt(req1_amt), .req1_mode(req1_mode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      logic        id;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic        port;
      logic [15:0] rs;
      logic [3:0]  amt;
      logic [1:0]  mode;
      logic [15:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bit-by-bit reference shifter.
   function automatic logic [15:0] m_shift(input logic [15:0] a, input logic [3:0] n,
                                           input logic [1:0] m);
      logic [15:0] r;
      int k;
      k = int'(n);
      r = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         case (m)
            2'b00:   r[i] = (i >= k) ? a[(i - k) & 15] : 1'b0;
            2'b10:   r[i] = a[(i + k) % 16];
            default: r[i] = (i + k <= 15) ? a[(i + k) & 15] : a[15];
         endcase
      end
      return r;
   endfunction

   // Scoreboard and handshake invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
         chk("ready_wo_valid", {31'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 32'd0);
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: response 0x%0h id %0d with nothing expected", rsp_data, rsp_id);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               chk("sb_data", {16'd0, rsp_data}, {16'd0, e.data});
               chk("sb_id", {31'd0, rsp_id}, {31'd0, e.id});
            end
         end
         if (req0_ready) sbq.push_back('{m_shift(req0_rs, req0_amt, req0_mode), 1'b0});
         if (req1_ready) sbq.push_back('{m_shift(req1_rs, req1_amt, req1_mode), 1'b1});
      end
   end

   task automatic set_req(input logic p, input logic v, input logic [15:0] rs,
                          input logic [3:0] amt, input logic [1:0] mode);
      if (p) begin
         req1_valid = v; req1_rs = rs; req1_amt = amt; req1_mode = mode;
      end else begin
         req0_valid = v; req0_rs = rs; req0_amt = amt; req0_mode = mode;
      end
   endtask

   // Present a request on port p and hold it until accepted (bounded).
   task automatic issue(input logic p, input logic [15:0] rs, input logic [3:0] amt,
                        input logic [1:0] mode, output int acc);
      @(posedge clk); #1;
      set_req(p, 1'b1, rs, amt, mode);
      acc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (p ? req1_ready : req0_ready) begin
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (acc < 0) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: port %0d never accepted", p);
      end
      @(posedge clk); #1;
      if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int c);
      c = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: rsp_valid never rose");
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
      chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_readys"}, {30'd0, req1_ready, req0_ready}, 32'd0);
   endtask

   // After a reset release: no stale response, and the first tie goes to port 0.
   task automatic post_reset_tie(input string tag);
      int c;
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_no_stale_valid"}, {31'd0, rsp_valid}, 32'd0);
         chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 16'h0003, 4'd1, 2'b00);
      set_req(1'b1, 1'b1, 16'h0005, 4'd1, 2'b00);
      @(negedge clk);
      chk({tag, "_tie_port0"}, {30'd0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(c);
      chk({tag, "_tie_rsp_id"}, {31'd0, rsp_id}, 32'd0);
      chk({tag, "_tie_rsp_data"}, {16'd0, rsp_data}, 32'h0006);
      @(negedge clk);
   endtask

   vec_t vecs[14];

   initial begin
      int acc, c, ng, last;
      logic expp, g, upd;
      logic [15:0] hd;
      logic        hid;

      vecs[0]  = '{1'b0, 16'h0001, 4'd4,  2'b00, 16'h0010};
      vecs[1]  = '{1'b0, 16'h8000, 4'd3,  2'b01, 16'hF000};
      vecs[2]  = '{1'b1, 16'h4000, 4'd3,  2'b01, 16'h0800};
      vecs[3]  = '{1'b0, 16'h1234, 4'd4,  2'b10, 16'h4123};
      vecs[4]  = '{1'b1, 16'h8000, 4'd1,  2'b11, 16'hC000};
      vecs[5]  = '{1'b0, 16'hA5A5, 4'd0,  2'b00, 16'hA5A5};
      vecs[6]  = '{1'b1, 16'hA5A5, 4'd0,  2'b01, 16'hA5A5};
      vecs[7]  = '{1'b0, 16'hA5A5, 4'd0,  2'b10, 16'hA5A5};
      vecs[8]  = '{1'b1, 16'hA5A5, 4'd0,  2'b11, 16'hA5A5};
      vecs[9]  = '{1'b0, 16'h0001, 4'd15, 2'b00, 16'h8000};
      vecs[10] = '{1'b1, 16'h8000, 4'd15, 2'b01, 16'hFFFF};
      vecs[11] = '{1'b0, 16'h0001, 4'd1,  2'b10, 16'h8000};
      vecs[12] = '{1'b1, 16'hF00F, 4'd8,  2'b10, 16'h0FF0};
      vecs[13] = '{1'b0, 16'hABCD, 4'd15, 2'b10, 16'h579B};

      // Reset with both requesters already valid.
      rst = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b0, 1'b1, 16'h1111, 4'd1, 2'b00);
      set_req(1'b1, 1'b1, 16'h2222, 4'd2, 2'b10);
      #12;
      chk_reset_vals("por");

      // Both continuously valid: grants alternate 0,1,0,... every 2 cycles.
      @(posedge clk); #1;
      rst = 1'b0;
      ng = 0; last = -1; expp = 1'b0; g = 1'b0;
      for (int i = 0; i < 40 && ng < 8; i++) begin
         @(negedge clk);
         upd = 1'b0;
         if (req0_ready || req1_ready) begin
            g = req1_ready;
            chk("alt_port", {31'd0, g}, {31'd0, expp});
            if (last >= 0) chk("alt_spacing", cyc - last, 32'd2);
            last = cyc;
            expp = ~expp;
            ng++;
            upd = 1'b1;
         end
         @(posedge clk); #1;
         if (upd) set_req(g, 1'b1, 16'($urandom), 4'($urandom), 2'($urandom));
      end
      chk("alt_count", ng, 32'd8);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Vector table: semantics and 2-cycle latency on a single port.
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].port, vecs[i].rs, vecs[i].amt, vecs[i].mode, acc);
         if (i == 0) begin
            @(negedge clk);
            chk("v0_exec_valid", {31'd0, rsp_valid}, 32'd0);
            chk("v0_exec_busy", {31'd0, busy}, 32'd1);
         end
         wait_rsp(c);
         chk($sformatf("vec%0d_latency", i), c - acc, 32'd2);
         chk($sformatf("vec%0d_data", i), {16'd0, rsp_data}, {16'd0, vecs[i].exp});
         chk($sformatf("vec%0d_id", i), {31'd0, rsp_id}, {31'd0, vecs[i].port});
         @(negedge clk);
         chk($sformatf("vec%0d_idle_valid", i), {31'd0, rsp_valid}, 32'd0);
         chk($sformatf("vec%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      end

      // Backpressure: held result stays put and port 1 waits.
      rsp_ready = 1'b0;
      issue(1'b0, 16'h0F0F, 4'd2, 2'b00, acc);
      set_req(1'b1, 1'b1, 16'h8001, 4'd1, 2'b10);
      wait_rsp(c);
      hd = rsp_data;
      hid = rsp_id;
      chk("bp_first_data", {16'd0, hd}, 32'h3C3C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data_held", {16'd0, rsp_data}, {16'd0, hd});
         chk("bp_id_held", {31'd0, rsp_id}, {31'd0, hid});
         chk("bp_req1_ready_low", {31'd0, req1_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
      acc = cyc;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("bp_exec_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_second_latency", cyc - acc, 32'd2);
      chk("bp_second_id", {31'd0, rsp_id}, 32'd1);
      chk("bp_second_data", {16'd0, rsp_data}, 32'hC000);
      @(negedge clk);

      // Reset while in EXEC (prio points at port 1 beforehand).
      issue(1'b0, 16'h00FF, 4'd4, 2'b00, acc);
      rst = 1'b1;
      set_req(1'b0, 1'b1, 16'h0001, 4'd1, 2'b00);
      set_req(1'b1, 1'b1, 16'h0001, 4'd1, 2'b00);
      #1;
      chk_reset_vals("rst_exec");
      post_reset_tie("rst_exec");

      // Reset while holding a result in RESP.
      rsp_ready = 1'b0;
      issue(1'b0, 16'h00FF, 4'd4, 2'b00, acc);
      wait_rsp(c);
      chk("rst_resp_pre_data", {16'd0, rsp_data}, 32'h0FF0);
      @(posedge clk); #1;
      rst = 1'b1;
      set_req(1'b0, 1'b1, 16'h0001, 4'd1, 2'b00);
      set_req(1'b1, 1'b1, 16'h0001, 4'd1, 2'b00);
      #1;
      chk_reset_vals("rst_resp");
      post_reset_tie("rst_resp");

      repeat (3) @(negedge clk);
      chk("sb_drained", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
